// File: rtl/packet_writer.sv
// packet_writer: assembles demodulated symbols LSB-first into DATA_W-bit
// words and writes them to consecutive memory addresses starting at 0.
// A packet is started with pkt_start/pkt_size, can be cancelled with abort,
// and ends with a one-cycle pkt_done pulse after the last word is written.
//
// Handshake: pkt_start and sym_valid are single-cycle strobes with no
// back-pressure; a strobe is consumed on the rising edge where it is high
// and the FSM is in a state that accepts it (pkt_start in IDLE, sym_valid
// in COLLECT). Strobes seen in other states are dropped.
module packet_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_start,
  input  logic [ADDR_W-1:0] pkt_size,
  input  logic              abort,
  input  logic              sym_valid,
  input  logic              sym_val,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              pkt_done,
  output logic              aborted,
  output logic [1:0]        state_dbg
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              pkt_done_q, pkt_done_d;
  logic              aborted_q, aborted_d;

  logic              sym_take;
  logic              byte_full;
  logic              last_byte;
  logic [DATA_W-1:0] byte_asm;

  // Symbol acceptance: abort wins over a coincident symbol.
  assign sym_take  = (state_q == S_COLLECT) && sym_valid && !abort;
  assign byte_full = sym_take && (bit_cnt_q == LAST_BIT);
  assign last_byte = (byte_cnt_q == (size_q - 1'b1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          state_d = (pkt_size == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (byte_full && last_byte) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs driven by the current state.
  always_comb begin
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pkt_done_d = (state_q == S_DONE);
    aborted_d  = (state_q == S_COLLECT) && abort;
    byte_asm   = shift_q;
    byte_asm[bit_cnt_q] = sym_val;

    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          size_d     = pkt_size;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          // Partial word is thrown away; nothing reaches memory.
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end else if (sym_valid) begin
          if (bit_cnt_q == LAST_BIT) begin
            mem_we_d   = 1'b1;
            mem_addr_d = byte_cnt_q;
            mem_data_d = byte_asm;
            byte_cnt_d = byte_cnt_q + 1'b1;
            bit_cnt_d  = '0;
            shift_d    = '0;
          end else begin
            shift_d   = byte_asm;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q     <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      pkt_done_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      pkt_done_q <= pkt_done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign pkt_done  = pkt_done_q;
  assign aborted   = aborted_q;
  assign busy      = (state_q == S_COLLECT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_packet_writer.sv
// Directed bench for packet_writer: one task per scenario, inline checks.
module tb_packet_writer;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pkt_start = 1'b0;
  logic [AW-1:0] pkt_size = '0;
  logic          abort = 1'b0;
  logic          sym_valid = 1'b0;
  logic          sym_val = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic          pkt_done;
  logic          aborted;
  logic [1:0]    state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int busy_cnt = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];
  int            abrt_cyc_q[$];
  logic [DW-1:0] exp_q[$];

  packet_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_size(pkt_size),
    .abort(abort), .sym_valid(sym_valid), .sym_val(sym_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .pkt_done(pkt_done), .aborted(aborted), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
      wr_cyc_q.push_back(cyc);
    end
    if (pkt_done === 1'b1) done_cyc_q.push_back(cyc);
    if (aborted === 1'b1) abrt_cyc_q.push_back(cyc);
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    abrt_cyc_q.delete();
    exp_q.delete();
    busy_cnt = 0;
  endtask

  task automatic start_pkt(input logic [AW-1:0] sz);
    pkt_size  = sz;
    pkt_start = 1'b1;
    step();
    pkt_start = 1'b0;
  endtask

  // Sends one word LSB-first, one symbol every 'gap' cycles.
  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    for (int i = 0; i < DW; i++) begin
      sym_valid = 1'b1;
      sym_val   = b[i];
      step();
      sym_valid = 1'b0;
      repeat (gap - 1) step();
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    sym_valid = 1'b1;
    pkt_start = 1'b1;
    pkt_size  = 8'd4;
    step();
    tests_run++;
    if ({mem_we, mem_addr, mem_data, busy, pkt_done, aborted, state_dbg} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0h expected 0",
               {mem_we, mem_addr, mem_data, busy, pkt_done, aborted, state_dbg});
    end
    sym_valid = 1'b0;
    pkt_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_log();
    start_pkt(8'd1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_edge_busy: got %b expected 1", busy);
    end
    send_byte(8'h3C, 1);
    repeat (3) step();
    tests_run++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'h3C || wr_addr_q[0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_first_pkt: got %0d writes (first %0h) expected 1 write of 3c",
               wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00);
    end
  endtask

  task automatic test_basic();
    clear_log();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h0F);
    start_pkt(8'd2);
    tests_run++;
    if (busy !== 1'b1 || state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL basic_busy: got busy=%b state=%0d expected busy=1 state=1", busy, state_dbg);
    end
    send_byte(8'h05, 4);
    send_byte(8'h0F, 4);
    repeat (4) step();
    tests_run++;
    if (wr_data_q.size() != 2) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d writes expected 2", wr_data_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (i >= wr_data_q.size()) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got none expected %0h", i, exp_q[i]);
      end else if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== AW'(i)) begin
        tests_failed++;
        $display("FAIL basic_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
      end
    end
    tests_run++;
    if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 32) begin
      tests_failed++;
      $display("FAIL basic_spacing: got %0d writes expected spacing 32", wr_cyc_q.size());
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || wr_cyc_q.size() != 2 || done_cyc_q[0] != wr_cyc_q[1] + 1) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d done pulses expected 1 pulse one cycle after last write",
               done_cyc_q.size());
    end
    tests_run++;
    if (mem_addr !== 8'd1 || mem_data !== 8'h0F || busy !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_hold: got addr %0h data %0h busy %b we %b expected 1 0f 0 0",
               mem_addr, mem_data, busy, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'hC3);
    start_pkt(8'd3);
    for (int i = 0; i < 3; i++) send_byte(exp_q[i], 1);
    repeat (4) step();
    tests_run++;
    if (wr_data_q.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d writes expected 3", wr_data_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++;
      if (i >= wr_data_q.size()) begin
        tests_failed++;
        $display("FAIL b2b_write%0d: got none expected %0h", i, exp_q[i]);
      end else if (wr_data_q[i] !== exp_q[i] || wr_addr_q[i] !== AW'(i)) begin
        tests_failed++;
        $display("FAIL b2b_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                 i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
      end
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      tests_run++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 8) begin
        tests_failed++;
        $display("FAIL b2b_spacing%0d: got %0d cycles expected 8", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || wr_cyc_q.size() != 3 || done_cyc_q[0] != wr_cyc_q[2] + 1) begin
      tests_failed++;
      $display("FAIL b2b_done: got %0d done pulses expected 1 after last write", done_cyc_q.size());
    end
  endtask

  task automatic test_zero_size();
    int c0;
    clear_log();
    start_pkt(8'd0);
    c0 = cyc;
    tests_run++;
    if (busy !== 1'b0 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL zero_state: got busy=%b state=%0d expected busy=0 state=2", busy, state_dbg);
    end
    repeat (4) step();
    tests_run++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 1) begin
      tests_failed++;
      $display("FAIL zero_done: got %0d pulses (first at %0d) expected 1 at %0d",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, c0 + 1);
    end
    tests_run++;
    if (wr_data_q.size() != 0 || busy_cnt != 0) begin
      tests_failed++;
      $display("FAIL zero_quiet: got %0d writes %0d busy cycles expected 0 0",
               wr_data_q.size(), busy_cnt);
    end
  endtask

  task automatic test_abort();
    clear_log();
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if (aborted !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL abort_idle: got aborted=%b state=%0d expected 0 0", aborted, state_dbg);
    end
    start_pkt(8'd3);
    send_byte(8'h12, 1);
    for (int i = 0; i < 7; i++) begin
      sym_valid = 1'b1;
      sym_val   = 1'b1;
      step();
    end
    abort = 1'b1;
    step();
    abort     = 1'b0;
    sym_valid = 1'b0;
    tests_run++;
    if (aborted !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_pulse: got aborted=%b busy=%b we=%b expected 1 0 0", aborted, busy, mem_we);
    end
    step();
    tests_run++;
    if (aborted !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_one_cycle: got aborted=%b expected 0", aborted);
    end
    repeat (3) step();
    tests_run++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'h12 || abrt_cyc_q.size() != 1 || done_cyc_q.size() != 0) begin
      tests_failed++;
      $display("FAIL abort_writes: got %0d writes %0d aborts %0d dones expected 1 1 0",
               wr_data_q.size(), abrt_cyc_q.size(), done_cyc_q.size());
    end
    clear_log();
    start_pkt(8'd1);
    send_byte(8'h5A, 1);
    repeat (3) step();
    tests_run++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'h5A || wr_addr_q[0] !== 8'd0 || done_cyc_q.size() != 1) begin
      tests_failed++;
      $display("FAIL abort_next_pkt: got %0d writes %0d dones expected one write 5a at 0 and 1 done",
               wr_data_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    start_pkt(8'd3);
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    tests_run++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_data !== 8'h44) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got we=%b addr=%0h data=%0h expected 1 1 44", mem_we, mem_addr, mem_data);
    end
    sym_valid = 1'b1;
    sym_val   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_we, mem_addr, mem_data, busy, pkt_done, aborted, state_dbg} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %0h expected 0",
               {mem_we, mem_addr, mem_data, busy, pkt_done, aborted, state_dbg});
    end
    sym_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    step();
    tests_run++;
    if (done_cyc_q.size() != 0 || abrt_cyc_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_pulse: got %0d dones %0d aborts busy=%b expected 0 0 0",
               done_cyc_q.size(), abrt_cyc_q.size(), busy);
    end
    clear_log();
    start_pkt(8'd1);
    send_byte(8'hA5, 1);
    repeat (3) step();
    tests_run++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 8'hA5 || wr_addr_q[0] !== 8'd0 || done_cyc_q.size() != 1) begin
      tests_failed++;
      $display("FAIL rstmid_after: got %0d writes %0d dones expected one write a5 at 0 and 1 done",
               wr_data_q.size(), done_cyc_q.size());
    end
  endtask

  task automatic test_restart_ignored();
    logic [DW-1:0] b0;
    b0 = 8'hC0;
    clear_log();
    sym_valid = 1'b1;
    sym_val   = 1'b1;
    repeat (2) step();
    sym_valid = 1'b0;
    start_pkt(8'd2);
    for (int i = 0; i < DW; i++) begin
      sym_valid = 1'b1;
      sym_val   = b0[i];
      pkt_start = (i == 3);
      pkt_size  = (i == 3) ? 8'd5 : 8'd2;
      step();
    end
    pkt_start = 1'b0;
    sym_valid = 1'b0;
    send_byte(8'h03, 1);
    repeat (12) step();
    tests_run++;
    if (wr_data_q.size() != 2) begin
      tests_failed++;
      $display("FAIL restart_count: got %0d writes expected 2", wr_data_q.size());
    end else if (wr_data_q[0] !== 8'hC0 || wr_data_q[1] !== 8'h03 || wr_addr_q[1] !== 8'd1) begin
      tests_failed++;
      $display("FAIL restart_data: got %0h %0h expected c0 03", wr_data_q[0], wr_data_q[1]);
    end
    tests_run++;
    if (done_cyc_q.size() != 1 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL restart_done: got %0d dones busy=%b state=%0d expected 1 0 0",
               done_cyc_q.size(), busy, state_dbg);
    end
  endtask

  task automatic test_max_size();
    int bad;
    clear_log();
    bad = 0;
    start_pkt(8'd255);
    for (int b = 0; b < 255; b++) send_byte(DW'(b), 1);
    repeat (4) step();
    tests_run++;
    if (wr_data_q.size() != 255) begin
      tests_failed++;
      $display("FAIL max_count: got %0d writes expected 255", wr_data_q.size());
    end
    for (int i = 0; i < wr_data_q.size() && i < 255; i++) begin
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== DW'(i)) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL max_writes: got %0d bad writes expected 0", bad);
    end
    tests_run++;
    if (mem_addr !== 8'd254 || done_cyc_q.size() != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_end: got addr %0h dones %0d busy %b expected fe 1 0",
               mem_addr, done_cyc_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_size();
    test_abort();
    test_reset_mid();
    test_restart_ignored();
    test_max_size();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/packet_writer.md
PACKET_WRITER -- requirements
Module: packet_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, bits per memory word and symbols per byte.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port pkt_start  input  1  single-cycle request to begin receiving a packet.
REQ-006 The block SHALL have port pkt_size  input  ADDR_W  packet length in bytes, sampled when pkt_start is accepted.
REQ-007 The block SHALL have port abort  input  1  cancels the packet in progress.
REQ-008 The block SHALL have port sym_valid  input  1  single-cycle strobe from the demodulator marking one decided symbol.
REQ-009 The block SHALL have port sym_val  input  1  decided symbol value, qualified by sym_valid.
REQ-010 The block SHALL have port mem_we  output  1  memory write enable, one-cycle pulse per byte.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  write address.
REQ-012 The block SHALL have port mem_data  output  DATA_W  write data.
REQ-013 The block SHALL have port busy  output  1  high while a packet is being received.
REQ-014 The block SHALL have port pkt_done  output  1  one-cycle pulse when the last byte has been written.
REQ-015 The block SHALL have port aborted  output  1  one-cycle pulse when a packet is cancelled.

Function
REQ-016 The block SHALL implement states IDLE, COLLECT, DONE.
REQ-017 In IDLE, the block SHALL accept pkt_start: a non-zero pkt_size is latched, bit and byte counters cleared, and the state goes to COLLECT; pkt_size=0 goes straight to DONE.
REQ-018 The block SHALL ignore pkt_start outside IDLE, and SHALL ignore sym_valid in IDLE and DONE.
REQ-019 In COLLECT, each sym_valid SHALL shift sym_val into the byte register LSB-first; the first symbol lands in bit 0.
REQ-020 On the edge that accepts the DATA_W-th symbol of byte k, the block SHALL register mem_data=assembled byte, mem_addr=k and mem_we=1, so the write is visible 1 cycle after the last bit.
REQ-021 mem_we SHALL be high for exactly one cycle, and mem_addr/mem_data SHALL hold their values until the next write.
REQ-022 Symbol collection SHALL continue without a gap: a sym_valid in the cycle where mem_we is high SHALL be accepted as bit 0 of byte k+1.
REQ-023 The byte counter SHALL be ADDR_W bits wide; when byte k = pkt_size-1 is written, the state SHALL go to DONE on the same edge.
REQ-024 DONE SHALL last one cycle, pulse pkt_done=1 (the cycle after the last mem_we), then return to IDLE.
REQ-025 When abort is high in COLLECT, the state SHALL go to IDLE, aborted SHALL pulse for one cycle, the partial byte SHALL be discarded, and mem_we SHALL NOT assert for it.
REQ-026 abort SHALL take priority over a simultaneous sym_valid that would complete a byte, so no write occurs.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 busy SHALL be 1 exactly in COLLECT.
REQ-029 pkt_size=2^ADDR_W-1 SHALL write addresses 0..254 with no wrap.

Reset
REQ-030 While rst=1, the block SHALL hold state=IDLE, mem_we=0, mem_addr=0, mem_data=0, busy=0, pkt_done=0, aborted=0, and all counters and the shift register at 0.
REQ-031 Reset asserted mid-packet SHALL immediately drop mem_we and busy, with no pkt_done or aborted pulse.
REQ-032 After rst deasserts, the first rising edge SHALL evaluate IDLE.

Verification
REQ-033 The bench SHALL drive pkt_size=2 and symbols 1,0,1,0,0,0,0,0 then 1,1,1,1,0,0,0,0 at one sym_valid per 4 cycles, and check two writes (addr0=0x05, addr1=0x0F) and a pkt_done pulse 1 cycle after the second mem_we.
REQ-034 The bench SHALL drive back-to-back sym_valid every cycle for pkt_size=3, and check a write every 8 cycles with no lost symbol at byte boundaries.
REQ-035 The bench SHALL drive pkt_start with pkt_size=0, and check pkt_done 1 cycle later, no mem_we, and busy stays 0.
REQ-036 The bench SHALL assert abort coincident with the 8th symbol of byte 1, and check no mem_we for byte 1, an aborted pulse, busy=0, and a following packet writing from addr 0.
REQ-037 The bench SHALL assert rst mid-byte, and check all outputs return to 0 asynchronously, then a full 1-byte packet 0xA5 writes correctly.
REQ-038 The bench SHALL assert pkt_start during COLLECT with a different pkt_size, and check it is ignored and the original length completes.
